// File: rtl/alu_issue_unit_if.sv
// Request and result handshake bundle between decode, the ALU issue unit and writeback.
// Both channels use valid/ready: a transfer happens on a rising clock edge where valid and ready are both high.
interface alu_issue_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_illegal;

    modport master (
        output in_valid, alu_op, funct, opa, opb, res_ready,
        input  in_ready, res_valid, res_data, res_zero, res_illegal
    );

    modport slave (
        input  in_valid, alu_op, funct, opa, opb, res_ready,
        output in_ready, res_valid, res_data, res_zero, res_illegal
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Two-stage ALU wrapper: S1 decodes and registers operands toward the ALU,
// S2 captures the combinational ALU result for writeback.
module alu_issue_unit #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_issue_unit_if.slave      bus,
    output logic [WIDTH-1:0]     alu_left,
    output logic [WIDTH-1:0]     alu_right,
    output logic [3:0]           alu_control,
    input  logic [WIDTH-1:0]     alu_out,
    output logic [CNT_WIDTH-1:0] ops_done
);
    logic             s1_valid;
    logic             s1_illegal;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_zero_q;
    logic             res_illegal_q;

    logic [3:0] dec_control;
    logic       dec_illegal;

    logic s2_free;
    logic s1_adv;
    logic ready;
    logic accept;
    logic consume;

    always_comb begin
        dec_control = 4'b0010;
        dec_illegal = 1'b0;
        case (bus.alu_op)
            2'b00: dec_control = 4'b0010;
            2'b01: dec_control = 4'b0110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: dec_control = 4'b0010;
                    6'b100010: dec_control = 4'b0110;
                    6'b100100: dec_control = 4'b0000;
                    6'b100101: dec_control = 4'b0001;
                    6'b101010: dec_control = 4'b0111;
                    6'b100111: dec_control = 4'b1100;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // in_ready looks through S2 so a full pipe can still accept when the consumer drains this cycle.
    assign s2_free = !res_valid_q || bus.res_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign ready   = !s1_valid || s2_free;
    assign accept  = bus.in_valid && ready;
    assign consume = res_valid_q && bus.res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_illegal    <= 1'b0;
            alu_left      <= '0;
            alu_right     <= '0;
            alu_control   <= 4'b0000;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
            ops_done      <= '0;
        end else begin
            if (accept) begin
                s1_valid    <= 1'b1;
                s1_illegal  <= dec_illegal;
                alu_left    <= bus.opa;
                alu_right   <= bus.opb;
                alu_control <= dec_control;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                res_valid_q   <= 1'b1;
                res_data_q    <= alu_out;
                res_zero_q    <= (alu_out == '0);
                res_illegal_q <= s1_illegal;
            end else if (consume) begin
                res_valid_q <= 1'b0;
            end

            if (consume) begin
                ops_done <= ops_done + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.res_illegal = res_illegal_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: drives a reference ALU from the alu_* ports and
// scoreboards every consumed result against hand-computed values.
module tb_alu_issue_unit;
    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_unit_if #(.WIDTH(WIDTH)) bus();
    alu_issue_unit_if #(.WIDTH(WIDTH)) bus_small();

    logic [WIDTH-1:0]     alu_left, alu_right, alu_out;
    logic [3:0]           alu_control;
    logic [CNT_WIDTH-1:0] ops_done;
    logic [WIDTH-1:0]     small_left, small_right, small_out;
    logic [3:0]           small_control;
    logic [3:0]           small_done;

    alu_issue_unit #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .alu_left(alu_left), .alu_right(alu_right), .alu_control(alu_control),
        .alu_out(alu_out), .ops_done(ops_done)
    );

    // Narrow-counter copy sees the same request stream to exercise counter wrap.
    alu_issue_unit #(.WIDTH(WIDTH), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .reset(reset), .bus(bus_small.slave),
        .alu_left(small_left), .alu_right(small_right), .alu_control(small_control),
        .alu_out(small_out), .ops_done(small_done)
    );

    assign bus_small.in_valid  = bus.in_valid;
    assign bus_small.alu_op    = bus.alu_op;
    assign bus_small.funct     = bus.funct;
    assign bus_small.opa       = bus.opa;
    assign bus_small.opb       = bus.opb;
    assign bus_small.res_ready = bus.res_ready;

    function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                                                  input logic [3:0] c);
        case (c)
            4'b0000: return l & r;
            4'b0001: return l | r;
            4'b0010: return l + r;
            4'b0110: return l - r;
            4'b0111: return ($signed(l) < $signed(r)) ? WIDTH'(1) : WIDTH'(0);
            4'b1100: return ~(l | r);
            default: return '0;
        endcase
    endfunction

    assign alu_out   = alu_model(alu_left, alu_right, alu_control);
    assign small_out = alu_model(small_left, small_right, small_control);

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic [WIDTH+1:0] exp_q[$];
    bit bp_done;
    int bp_sent;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: entry is {illegal, zero, data}, popped when a result transfers.
    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", bus.res_valid, 0);
            end else begin
                check("sb_result", {bus.res_illegal, bus.res_zero, bus.res_data}, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] fn,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.funct    = fn;
        bus.opa      = a;
        bus.opb      = b;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", acc, 1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1);
        check("drain_empty", exp_q.size(), 0);
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0]       dec_fn[4]  = '{6'b100100, 6'b100101, 6'b101010, 6'b100111};
        logic [3:0]       dec_ctl[4] = '{4'b0000, 4'b0001, 4'b0111, 4'b1100};
        logic [WIDTH-1:0] dec_res[4] = '{32'h0000_0000, 32'h0000_0FFF, 32'h0000_0001, 32'hFFFF_F000};
        int start_cyc;

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_op = 2'b00;
        bus.funct = 6'd0;
        bus.opa = '0;
        bus.opb = '0;
        bus.res_ready = 1'b0;
        step(2);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_ctrl", alu_control, 0);
        check("rst_ops_done", ops_done, 0);
        reset = 1'b0;
        step(1);

        // Single add with latency check
        bus.res_ready = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'd12});
        send(2'b10, 6'b100000, 32'd5, 32'd7);
        idle();
        check("add_left", alu_left, 5);
        check("add_right", alu_right, 7);
        check("add_ctrl", alu_control, 4'b0010);
        check("add_lat0", bus.res_valid, 0);
        step(1);
        check("add_lat1", bus.res_valid, 1);
        check("add_data", bus.res_data, 12);
        check("add_zero", bus.res_zero, 0);
        step(2);

        // Branch subtract to zero
        exp_q.push_back({1'b0, 1'b1, 32'd0});
        send(2'b01, 6'b000000, 32'd9, 32'd9);
        idle();
        check("sub_ctrl", alu_control, 4'b0110);
        step(1);
        check("sub_zero", bus.res_zero, 1);
        step(2);

        // R-type decode coverage
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, dec_res[k] == '0, dec_res[k]});
            send(2'b10, dec_fn[k], 32'h0000_00F0, 32'h0000_0F0F);
            idle();
            check("dec_ctrl", alu_control, dec_ctl[k]);
            step(2);
        end

        // Illegal requests still flow through as adds
        exp_q.push_back({1'b1, 1'b0, 32'd7});
        send(2'b10, 6'b000000, 32'd3, 32'd4);
        idle();
        check("ill_funct_ctrl", alu_control, 4'b0010);
        step(1);
        check("ill_funct_flag", bus.res_illegal, 1);
        step(1);
        exp_q.push_back({1'b1, 1'b0, 32'd2});
        send(2'b11, 6'b100100, 32'd1, 32'd1);
        idle();
        check("ill_op_ctrl", alu_control, 4'b0010);
        step(1);
        check("ill_op_flag", bus.res_illegal, 1);
        step(1);
        exp_q.push_back({1'b0, 1'b0, 32'd3});
        send(2'b00, 6'b000000, 32'd1, 32'd2);
        idle();
        step(1);
        check("legal_flag_clear", bus.res_illegal, 0);
        step(2);

        // Backpressure: four adds, consumer stalled for five cycles
        bus.res_ready = 1'b0;
        bp_done = 1'b0;
        bp_sent = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, WIDTH'(2 * (i + 1))});
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(2'b00, 6'd0, WIDTH'(i + 1), WIDTH'(i + 1));
                    bp_sent++;
                end
                idle();
                bp_done = 1'b1;
            end
        join_none
        step(5);
        check("bp_accepts", bp_sent, 2);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_res_valid", bus.res_valid, 1);
        check("bp_res_data", bus.res_data, 2);
        check("bp_left", alu_left, 2);
        step(1);
        check("bp_hold_data", bus.res_data, 2);
        check("bp_hold_left", alu_left, 2);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 60 && !bp_done; i++) step(1);
        check("bp_sends_done", bp_done, 1);
        drain();
        check("pre_mid_done", ops_done, 13);
        check("pre_mid_small", small_done, 13);

        // Reset with both stages full
        bus.res_ready = 1'b0;
        exp_q.push_back({1'b1, 1'b1, 32'd0});
        send(2'b11, 6'd0, 32'hFFFF_FFFF, 32'd1);
        exp_q.push_back({2'b00, 32'd11});
        send(2'b00, 6'd0, 32'd5, 32'd6);
        idle();
        step(1);
        check("mid_full_res", bus.res_valid, 1);
        check("mid_full_left", alu_left, 5);
        check("mid_full_ill", bus.res_illegal, 1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_data", bus.res_data, 0);
        check("mid_rst_zero", bus.res_zero, 0);
        check("mid_rst_illegal", bus.res_illegal, 0);
        check("mid_rst_left", alu_left, 0);
        check("mid_rst_right", alu_right, 0);
        check("mid_rst_ctrl", alu_control, 0);
        check("mid_rst_done", ops_done, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        step(1);
        reset = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("post_rst_no_result", bus.res_valid, 0);
        end
        check("post_rst_done", ops_done, 0);

        // Throughput and counter wrap
        start_cyc = cycle;
        for (int k = 0; k < 17; k++) begin
            exp_q.push_back({2'b00, WIDTH'(k + 1)});
            send(2'b10, 6'b100000, WIDTH'(k), WIDTH'(1));
        end
        check("tp_cycles", cycle - start_cyc, 17);
        idle();
        drain();
        check("tp_done17", ops_done, 17);
        check("tp_small17", small_done, 1);
        for (int k = 17; k < 20; k++) begin
            exp_q.push_back({2'b00, WIDTH'(k + 1)});
            send(2'b10, 6'b100000, WIDTH'(k), WIDTH'(1));
        end
        idle();
        drain();
        check("tp_done20", ops_done, 20);
        check("tp_small20", small_done, 4);
        check("tp_last_data", bus.res_data, 20);
        check("tp_small_data", bus_small.res_data, 20);
        check("tp_small_left", small_left, 19);
        check("tp_small_ctrl", small_control, 4'b0010);
        check("tp_small_idle", {bus_small.res_valid, bus_small.in_ready,
                                bus_small.res_zero, bus_small.res_illegal, small_right}, {4'b0100, 32'd1});
        check("sb_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
